// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_sequencer_pkg;

    // Controller phases: post-reset settle, request outstanding, instruction parked in IF/ID.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int PC_INC     = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: merges execute-stage redirects and hazard stalls into one
// PC-update decision per cycle and runs the instruction-memory req/ack handshake.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_wen,
    output logic              pc_branches,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              if_valid,
    output logic              if_kill,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES - 1);

    fetch_state_e      state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    // The PC feeds memory directly; this block only decides how it updates.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign fetch_count = fetch_count_q;

    // State, pending-redirect and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
            boot_cnt_q    <= BOOT_INIT;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            boot_cnt_q    <= boot_cnt_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state and combinational PC/IF-ID controls; redirect beats stall beats sequential.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        boot_cnt_d  = boot_cnt_q;
        pc_wen      = 1'b0;
        pc_branches = 1'b0;
        pc_addr     = '0;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        if_kill     = 1'b0;

        unique case (state_q)
            BOOT: begin
                if (boot_cnt_q == '0) state_d = REQ;
                else                  boot_cnt_d = boot_cnt_q - BOOT_W'(1);
            end
            REQ: begin
                imem_req = 1'b1;
                if (!imem_ack) begin
                    // Request stays up; remember the newest target until the ack lands.
                    if (redirect) begin
                        pend_d      = 1'b1;
                        pend_addr_d = redirect_addr;
                    end
                end else if (redirect || pend_q) begin
                    // Returned instruction is wrong-path: discard it and steer the PC.
                    if_kill     = 1'b1;
                    pc_wen      = 1'b1;
                    pc_branches = 1'b1;
                    pc_addr     = redirect ? redirect_addr : pend_addr_q;
                    pend_d      = 1'b0;
                end else begin
                    if_valid = 1'b1;
                    if (stall) state_d = HOLD;
                    else       pc_wen  = 1'b1;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                if (redirect) begin
                    if_valid    = 1'b0;
                    if_kill     = 1'b1;
                    pc_wen      = 1'b1;
                    pc_branches = 1'b1;
                    pc_addr     = redirect_addr;
                    state_d     = REQ;
                end else if (!stall) begin
                    pc_wen  = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        fetch_count_d = fetch_count_q;
        if (if_valid && !stall && !if_kill) fetch_count_d = fetch_count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer with a behavioural model of the fetch rules.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int AW = 32;
    localparam int CW = 32;
    localparam int BOOT_N = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          pc_wen, pc_branches, imem_req, if_valid, if_kill;
    logic [AW-1:0] pc_addr;
    logic          imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [CW-1:0] fetch_count;

    fetch_sequencer #(.ADDR_W(AW), .BOOT_CYCLES(BOOT_N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .pc_wen(pc_wen), .pc_branches(pc_branches), .pc_addr(pc_addr),
        .imem_req(imem_req), .imem_ack(imem_ack), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .if_valid(if_valid), .if_kill(if_kill), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          req, wen, br;
        logic [AW-1:0] addr;
        logic          valid, kill;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a fetch is either booting, waiting on memory, or parked behind a stall.
    int            boot_left;
    bit            booting, parked, has_target;
    logic [AW-1:0] target;
    logic [CW-1:0] delivered;
    logic [AW-1:0] pc_model;

    task automatic model_reset();
        booting = 1; boot_left = BOOT_N - 1; parked = 0;
        has_target = 0; target = '0; delivered = '0; pc_model = '0;
    endtask

    // One clock: drive inputs at the falling edge, predict outputs, advance the model.
    task automatic cyc(input bit rst, input bit ack, input bit stl, input bit rd, input logic [AW-1:0] ra);
        exp_t e;
        @(negedge clk);
        reset = ~rst; imem_ack = ack; stall = stl; redirect = rd; redirect_addr = ra; pc = pc_model;
        e = '0;
        if (rst) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        e.cnt = delivered;
        if (booting) begin
            if (boot_left == 0) booting = 0; else boot_left--;
        end else if (parked) begin
            if (rd) begin
                e.kill = 1; e.wen = 1; e.br = 1; e.addr = ra; parked = 0;
            end else begin
                e.valid = 1;
                if (!stl) begin e.wen = 1; parked = 0; end
            end
        end else begin
            e.req = 1;
            if (!ack) begin
                if (rd) begin has_target = 1; target = ra; end
            end else if (rd || has_target) begin
                e.kill = 1; e.wen = 1; e.br = 1;
                e.addr = rd ? ra : target;
                has_target = 0;
            end else begin
                e.valid = 1;
                if (stl) parked = 1; else e.wen = 1;
            end
        end
        if (e.valid && !stl && !e.kill) delivered = delivered + 1;
        if (e.wen) pc_model = e.br ? e.addr : pc_model + AW'(PC_INC);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{req: imem_req, wen: pc_wen, br: pc_branches, addr: pc_addr,
                      valid: if_valid, kill: if_kill, cnt: fetch_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t got req=%b wen=%b br=%b addr=%h v=%b k=%b cnt=%0d exp req=%b wen=%b br=%b addr=%h v=%b k=%b cnt=%0d",
                             $time, a.req, a.wen, a.br, a.addr, a.valid, a.kill, a.cnt,
                             e.req, e.wen, e.br, e.addr, e.valid, e.kill, e.cnt);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        // Reset, then zero-wait memory with ack tied high.
        cyc(1, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, '0);
        // Delayed ack with a redirect to 0x100 in the second wait cycle.
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 32'h100);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        // Two redirects before the ack: the later one wins, one kill.
        cyc(0, 0, 0, 1, 32'h40);
        cyc(0, 0, 0, 1, 32'h80);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        // Ack with stall held three cycles, then release.
        cyc(0, 1, 1, 0, '0);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        // Stall into hold, then redirect while still stalled.
        cyc(0, 1, 1, 0, '0);
        cyc(0, 0, 1, 1, 32'h200);
        cyc(0, 1, 0, 0, '0);
        // Reset while a request is outstanding; boot sequence repeats.
        cyc(0, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, '0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] ra;
            ra = {$urandom_range(0, 32'h3FFF), 2'b00};
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15), ra);
        end
        // Drain the scoreboard with a bounded wait.
        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            #3;
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
